bus_decoder: RTL and testbench
==============================

BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter N_SLV, default 8: number of decoded slave regions, 1..16.
REQ-002 Parameter ADDR_W, default 16: CPU address width.
REQ-003 Parameter DATA_W, default 8: data bus width.
REQ-004 Parameter SLV_BASE, default all zero: packed N_SLV x ADDR_W region base addresses; slot i in bits [i*ADDR_W +: ADDR_W].
REQ-005 Parameter SLV_MASK, default all zero: packed N_SLV x ADDR_W compare masks, same slot layout; a mask of zero disables that slot.
REQ-006 Parameter SLV_WAIT, default all zero: packed N_SLV x 4 wait-state counts, 0..15 per slot.
REQ-007 clk  in  1  single system clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 addr  in  ADDR_W  CPU address.
REQ-010 we  in  1  CPU write strobe.
REQ-011 slv_dbr  in  N_SLV*DATA_W  packed slave read data; slot i in bits [i*DATA_W +: DATA_W].
REQ-012 err_clr  in  1  clears the error flag and the error counter.
REQ-013 sel  out  N_SLV  combinational one-hot address-phase select.
REQ-014 slv_we  out  N_SLV  per-slave write enable.
REQ-015 sel_q  out  N_SLV  registered data-phase select.
REQ-016 dbr  out  DATA_W  CPU read data.
REQ-017 rdy  out  1  CPU ready; 0 stalls the CPU.
REQ-018 err  out  1  sticky unmapped-access flag.
REQ-019 err_cnt  out  8  count of unmapped accesses; saturates at 255.

Function
REQ-020 Slot i SHALL match when (addr & MASK_i) == (BASE_i & MASK_i) and MASK_i != 0.
REQ-021 sel SHALL be one-hot or zero: when several slots match, only the lowest-index slot is set.
REQ-022 slv_we[i] SHALL equal we & sel[i] & rdy, so each write reaches the slave exactly once, in the final cycle of its access.
REQ-023 sel_q SHALL load sel on every clock edge where rdy=1 and hold its value while rdy=0.
REQ-024 dbr SHALL be the bitwise AND over all i of (sel_q[i] ? slot i data : all ones); dbr is all ones when sel_q is zero.
REQ-025 The FSM SHALL have two states, IDLE and WAIT, plus a 4-bit counter wcnt.
REQ-026 IDLE, new address selecting slot k with SLV_WAIT[k] = W > 0 -> enter WAIT with wcnt = W.
- rdy SHALL be 0 combinationally during that cycle.
- A new address is one that differs from the address of the last completed cycle, or any first cycle after reset.
REQ-027 IDLE, SLV_WAIT = 0 or no slot selected -> rdy = 1, zero wait states.
REQ-028 WAIT -> wcnt decrements each cycle; rdy = 0 while wcnt > 1.
- rdy SHALL be 1 in the cycle where wcnt = 1; that cycle completes the access and the FSM returns to IDLE.
- An access with W wait states therefore lasts W+1 cycles.
REQ-029 addr changes while in WAIT -> abandon the access; reload wcnt from the new slot's SLV_WAIT, or go to IDLE with rdy = 1 if that value is 0 or no slot is selected; no slv_we pulse for the abandoned address.
REQ-030 An access completing with sel = 0 SHALL set err and increment err_cnt by 1, saturating at 255.
REQ-031 err_clr SHALL clear err and err_cnt on the next edge; if an unmapped access completes in the same cycle, err SHALL end at 1 and err_cnt at 1.
REQ-032 Decode, wait and read-mux logic SHALL contain no combinational path from slv_dbr to rdy or sel.

Reset
REQ-033 While rst = 0 at a clock edge, the block SHALL take the following values:
- FSM = IDLE, wcnt = 0;
- sel_q = 0, hence dbr = all ones;
- err = 0, err_cnt = 0;
- the last-address register is invalidated, so the first post-reset access counts as new.
REQ-034 During reset, rdy SHALL be 1 and slv_we SHALL be 0.
REQ-035 Reset asserted in the middle of a wait SHALL abort the access with no slv_we pulse.

Verification
REQ-036 Configuration: N_SLV=3; slot0 BASE=0x0000 MASK=0x8000 W=0; slot1 BASE=0xFE00 MASK=0xFFE0 W=2; slot2 BASE=0xFF00 MASK=0xFF00 W=0. Directed scenarios:
- Read addr=0x1234, slv_dbr slot0=0x5A -> sel=001, rdy stays 1, next cycle sel_q=001 and dbr=0x5A.
- Write addr=0xFE05 we=1 held -> rdy = 0,0,1 over 3 cycles; slv_we[1] pulses once, in the third cycle only.
- Read addr=0x9000 (unmapped) -> dbr=0xFF, err=1, err_cnt=1; repeat 300 accesses -> err_cnt=255; err_clr -> 0.
- Overlap: add slot3 BASE=0xFF00 MASK=0xFF00 -> addr=0xFF10 selects slot2 only.
- rst=0 in the cycle after 0xFE05 is presented -> next cycle rdy=1, sel_q=0, no slv_we; access to 0xFE05 after reset again takes 3 cycles.

Source files
------------

// File: rtl/bus_decoder.sv
// Address decoder with per-region wait states, data-phase read mux and unmapped-access error tracking.
// Latency: sel/slv_we/rdy are combinational in the address phase; sel_q/dbr follow one cycle later (data phase).
// Backpressure: rdy=0 stalls the CPU for SLV_WAIT cycles on a new access to a waited region; a slave cannot stall.
module bus_decoder #(
    parameter int                         N_SLV    = 8,
    parameter int                         ADDR_W   = 16,
    parameter int                         DATA_W   = 8,
    parameter logic [N_SLV*ADDR_W-1:0]    SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0]    SLV_MASK = '0,
    parameter logic [N_SLV*4-1:0]         SLV_WAIT = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          we,
    input  logic [N_SLV*DATA_W-1:0]       slv_dbr,
    input  logic                          err_clr,
    output logic [N_SLV-1:0]              sel,
    output logic [N_SLV-1:0]              slv_we,
    output logic [N_SLV-1:0]              sel_q,
    output logic [DATA_W-1:0]             dbr,
    output logic                          rdy,
    output logic                          err,
    output logic [7:0]                    err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    // Address seen on the previous clock edge. In IDLE this is always the
    // address of the last completed cycle (IDLE is only entered after a
    // completion or a reset), in WAIT it is the address being waited on.
    logic [ADDR_W-1:0]     prev_addr_q, prev_addr_d;
    logic                  prev_vld_q, prev_vld_d;
    logic [N_SLV-1:0]      sel_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [N_SLV-1:0]      match;
    logic [3:0]            hit_wait;
    logic                  hit_found;
    logic                  addr_new;
    logic                  rdy_fsm;
    logic                  unmapped_done;

    // Raw per-slot address compare; a zero mask disables the slot.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_SLV; i++) begin
            match[i] = (SLV_MASK[i*ADDR_W +: ADDR_W] != '0) &&
                       ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                        (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]));
        end
    end

    // Lowest-index match wins; also pick up that slot's wait-state count.
    always_comb begin
        sel       = '0;
        hit_wait  = '0;
        hit_found = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (match[i] && !hit_found) begin
                sel[i]    = 1'b1;
                hit_wait  = SLV_WAIT[i*4 +: 4];
                hit_found = 1'b1;
            end
        end
    end

    assign addr_new = !prev_vld_q || (addr != prev_addr_q);

    // Wait-state FSM: next state, wait counter and the raw ready.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rdy_fsm = 1'b1;
        case (state_q)
            IDLE: begin
                if (addr_new && (hit_wait != 4'd0)) begin
                    rdy_fsm = 1'b0;
                    state_d = WAIT;
                    wcnt_d  = hit_wait;
                end
            end
            WAIT: begin
                if (addr_new) begin
                    // CPU moved on: drop the old access and restart on the new address.
                    if (hit_wait != 4'd0) begin
                        rdy_fsm = 1'b0;
                        wcnt_d  = hit_wait;
                    end else begin
                        state_d = IDLE;
                        wcnt_d  = 4'd0;
                    end
                end else if (wcnt_q > 4'd1) begin
                    rdy_fsm = 1'b0;
                    wcnt_d  = wcnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    wcnt_d  = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // Reset forces ready high and suppresses every write strobe.
    assign rdy    = !rst || rdy_fsm;
    assign slv_we = sel & {N_SLV{we & rdy & rst}};

    // Data-phase select, address history and error bookkeeping.
    always_comb begin
        prev_addr_d   = addr;
        prev_vld_d    = 1'b1;
        sel_d         = rdy_fsm ? sel : sel_q;
        unmapped_done = rdy_fsm && (sel == '0);
        err_d         = err_q;
        err_cnt_d     = err_cnt_q;
        if (err_clr) begin
            err_d     = unmapped_done;
            err_cnt_d = unmapped_done ? 8'd1 : 8'd0;
        end else if (unmapped_done) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            prev_addr_q <= '0;
            prev_vld_q  <= 1'b0;
            sel_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            prev_addr_q <= prev_addr_d;
            prev_vld_q  <= prev_vld_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Read mux: AND of the selected slaves' data, all ones when nothing was selected.
    always_comb begin
        dbr = '1;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                dbr = dbr & slv_dbr[i*DATA_W +: DATA_W];
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: directed vectors with literal checks plus a per-cycle reference model.
// Latency: model predicts combinational outputs in-cycle and registered outputs one edge later.
// Backpressure: model counts cycles spent on each access and expects rdy after SLV_WAIT of them.
module tb_bus_decoder;

    localparam int N = 4;
    localparam logic [N*16-1:0] BASE_P = {16'hFF00, 16'hFF00, 16'hFE00, 16'h0000};
    localparam logic [N*16-1:0] MASK_P = {16'hFF00, 16'hFF00, 16'hFFE0, 16'h8000};
    localparam logic [N*4-1:0]  WAIT_P = {4'd0, 4'd0, 4'd2, 4'd0};

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     addr;
    logic            we;
    logic [N*8-1:0]  slv_dbr;
    logic            err_clr;
    logic [N-1:0]    sel, slv_we, sel_q;
    logic [7:0]      dbr;
    logic            rdy, err;
    logic [7:0]      err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bus_decoder #(
        .N_SLV(N), .ADDR_W(16), .DATA_W(8),
        .SLV_BASE(BASE_P), .SLV_MASK(MASK_P), .SLV_WAIT(WAIT_P)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .slv_dbr(slv_dbr),
        .err_clr(err_clr), .sel(sel), .slv_we(slv_we), .sel_q(sel_q),
        .dbr(dbr), .rdy(rdy), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cfg_base [N] = '{'h0000, 'hFE00, 'hFF00, 'hFF00};
    int          cfg_mask [N] = '{'h8000, 'hFFE0, 'hFF00, 'hFF00};
    int          cfg_wait [N] = '{0, 2, 0, 0};
    int          cfg_data [N] = '{'h5A, 'hC3, 'h33, 'h44};

    function automatic int region_of(input int a);
        for (int k = 0; k < N; k++)
            if (cfg_mask[k] != 0 && (a & cfg_mask[k]) == (cfg_base[k] & cfg_mask[k]))
                return k;
        return -1;
    endfunction

    bit  m_vld = 0;
    bit  m_pending = 0;       // an access is stalled and not yet complete
    int  m_acc_addr = 0;
    int  m_acc_cycles = 0;    // cycles already spent on the stalled access
    bit  m_last_vld = 0;
    int  m_last_addr = 0;
    int  m_selq_reg = -1;     // region index captured for the data phase
    bit  m_err = 0;
    int  m_cnt = 0;

    always begin
        int  a, r, w, spent;
        bit  exp_rdy, unm, rs, clr;
        logic [N-1:0] exp_sel, exp_we, exp_selq;
        int  exp_dbr;
        @(negedge clk);
        a  = int'(addr);
        rs = rst;
        clr = err_clr;
        r  = region_of(a);
        w  = (r < 0) ? 0 : cfg_wait[r];
        if (m_pending && a == m_acc_addr)            spent = m_acc_cycles;
        else if (!m_pending && m_last_vld && a == m_last_addr) spent = w;   // repeat of a finished cycle
        else                                          spent = 0;
        exp_rdy  = !rs || (spent >= w);
        exp_sel  = (r < 0) ? '0 : N'(1 << r);
        exp_we   = (rs && we && exp_rdy) ? exp_sel : '0;
        exp_selq = (m_selq_reg < 0) ? '0 : N'(1 << m_selq_reg);
        exp_dbr  = (m_selq_reg < 0) ? 'hFF : cfg_data[m_selq_reg];
        unm      = rs && exp_rdy && (r < 0);
        if (m_vld) begin
            chk("m_sel", 32'(sel), 32'(exp_sel));
            chk("m_rdy", 32'(rdy), 32'(exp_rdy));
            chk("m_slv_we", 32'(slv_we), 32'(exp_we));
            chk("m_sel_q", 32'(sel_q), 32'(exp_selq));
            chk("m_dbr", 32'(dbr), 32'(exp_dbr));
            chk("m_err", 32'(err), 32'(m_err));
            chk("m_err_cnt", 32'(err_cnt), 32'(m_cnt));
        end
        @(posedge clk);
        m_vld = 1;
        if (!rs) begin
            m_pending = 0; m_last_vld = 0; m_selq_reg = -1; m_err = 0; m_cnt = 0;
        end else begin
            if (exp_rdy) begin
                m_pending = 0; m_last_vld = 1; m_last_addr = a; m_selq_reg = r;
            end else begin
                m_pending = 1; m_acc_addr = a; m_acc_cycles = spent + 1;
            end
            if (clr) begin
                m_err = unm; m_cnt = unm ? 1 : 0;
            end else if (unm) begin
                m_err = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r, input logic [15:0] a, input logic w, input logic c);
        @(posedge clk);
        #1;
        rst = r; addr = a; we = w; err_clr = c;
        #1;
    endtask

    initial begin
        rst = 1'b0; addr = 16'h0000; we = 1'b1; err_clr = 1'b0;
        slv_dbr = {8'h44, 8'h33, 8'hC3, 8'h5A};

        // reset state
        drive(0, 16'h0000, 1, 0);
        chk("rst_rdy", 32'(rdy), 32'h1);
        chk("rst_slv_we", 32'(slv_we), 32'h0);
        chk("rst_sel_q", 32'(sel_q), 32'h0);
        chk("rst_dbr", 32'(dbr), 32'hFF);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);

        // zero-wait read of slot 0
        drive(1, 16'h1234, 0, 0);
        chk("a_sel", 32'(sel), 32'h1);
        chk("a_rdy", 32'(rdy), 32'h1);
        drive(1, 16'h1234, 0, 0);
        chk("a_sel_q", 32'(sel_q), 32'h1);
        chk("a_dbr", 32'(dbr), 32'h5A);

        // two-wait write to slot 1
        drive(1, 16'hFE05, 1, 0);
        chk("b_rdy0", 32'(rdy), 32'h0);
        chk("b_we0", 32'(slv_we), 32'h0);
        drive(1, 16'hFE05, 1, 0);
        chk("b_rdy1", 32'(rdy), 32'h0);
        chk("b_we1", 32'(slv_we), 32'h0);
        drive(1, 16'hFE05, 1, 0);
        chk("b_rdy2", 32'(rdy), 32'h1);
        chk("b_we2", 32'(slv_we), 32'h2);
        drive(1, 16'h1234, 0, 0);
        chk("b_sel_q", 32'(sel_q), 32'h2);
        chk("b_dbr", 32'(dbr), 32'hC3);
        chk("b_we_after", 32'(slv_we), 32'h0);

        // unmapped access, saturation and clear
        drive(1, 16'h9000, 0, 0);
        chk("c_sel", 32'(sel), 32'h0);
        chk("c_rdy", 32'(rdy), 32'h1);
        drive(1, 16'h1234, 0, 0);
        chk("c_err", 32'(err), 32'h1);
        chk("c_cnt", 32'(err_cnt), 32'h1);
        chk("c_dbr", 32'(dbr), 32'hFF);
        for (int i = 0; i < 300; i++) drive(1, 16'h9000, 0, 0);
        drive(1, 16'h1234, 0, 0);
        chk("c_sat", 32'(err_cnt), 32'd255);
        drive(1, 16'h1234, 0, 1);
        drive(1, 16'h1234, 0, 0);
        chk("c_clr_err", 32'(err), 32'h0);
        chk("c_clr_cnt", 32'(err_cnt), 32'h0);
        drive(1, 16'h9000, 0, 1);
        drive(1, 16'h1234, 0, 0);
        chk("c_both_err", 32'(err), 32'h1);
        chk("c_both_cnt", 32'(err_cnt), 32'h1);

        // overlapping regions: lowest index wins
        drive(1, 16'hFF10, 0, 0);
        chk("d_sel", 32'(sel), 32'h4);
        drive(1, 16'hFF10, 0, 0);
        chk("d_sel_q", 32'(sel_q), 32'h4);
        chk("d_dbr", 32'(dbr), 32'h33);

        // abandoned waits
        drive(1, 16'hFE05, 1, 0);
        chk("e_rdy0", 32'(rdy), 32'h0);
        drive(1, 16'hFF10, 1, 0);
        chk("e_rdy_sw", 32'(rdy), 32'h1);
        chk("e_we_sw", 32'(slv_we), 32'h4);
        drive(1, 16'hFE05, 1, 0);
        drive(1, 16'hFE06, 1, 0);
        chk("e_rdy_rl", 32'(rdy), 32'h0);
        chk("e_we_rl", 32'(slv_we), 32'h0);
        drive(1, 16'hFE06, 1, 0);
        chk("e_rdy_rl1", 32'(rdy), 32'h0);
        drive(1, 16'hFE06, 1, 0);
        chk("e_rdy_rl2", 32'(rdy), 32'h1);
        chk("e_we_rl2", 32'(slv_we), 32'h2);

        // reset in the middle of a wait
        drive(1, 16'h1234, 0, 0);
        drive(1, 16'hFE05, 1, 0);
        chk("f_rdy0", 32'(rdy), 32'h0);
        drive(0, 16'hFE05, 1, 0);
        chk("f_rst_rdy", 32'(rdy), 32'h1);
        chk("f_rst_we", 32'(slv_we), 32'h0);
        drive(1, 16'hFE05, 1, 0);
        chk("f_sel_q", 32'(sel_q), 32'h0);
        chk("f_dbr", 32'(dbr), 32'hFF);
        chk("f_rdy_a", 32'(rdy), 32'h0);
        chk("f_we_a", 32'(slv_we), 32'h0);
        drive(1, 16'hFE05, 1, 0);
        chk("f_rdy_b", 32'(rdy), 32'h0);
        drive(1, 16'hFE05, 1, 0);
        chk("f_rdy_c", 32'(rdy), 32'h1);
        chk("f_we_c", 32'(slv_we), 32'h2);

        drive(1, 16'h0000, 0, 0);
        drive(1, 16'h0000, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
